// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Imported by the top module and the read-port sub-module.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;
    localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage mux, optional write forwarding,
// optional hardwired-zero entry 0.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0
) (
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic [ADDR_W-1:0] addr,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = mem[addr];
        if (BYPASS != 0) begin
            // Port 1 wins, matching the write-commit priority.
            if (we1 && (wa1 == addr)) begin
                data = wd1;
            end else if (we0 && (wa0 == addr)) begin
                data = wd0;
            end
        end
        // Zero entry masks everything, forwarded data included.
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, two write
// ports (port 1 has priority), and a one-entry-per-cycle background clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     wr_collide
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              clr_busy_reg, clr_busy_next;
    logic              wr_collide_reg, wr_collide_next;
    logic              clr_active;

    // Clear engine: IDLE waits for a request, SWEEP zeroes idx each cycle.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        clr_active = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end
            end
            SWEEP: begin
                clr_active = 1'b1;
                if (idx_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
        clr_busy_next   = (state_next == SWEEP);
        wr_collide_next = we0 && we1 && (wa0 == wa1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            clr_busy_reg   <= 1'b0;
            wr_collide_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            clr_busy_reg   <= clr_busy_next;
            wr_collide_reg <= wr_collide_next;
        end
    end

    assign clr_busy   = clr_busy_reg;
    assign wr_collide = wr_collide_reg;

    // Per-entry storage: external writes beat the sweep on the same entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_reg[gi] <= '0;
            end else if ((ZERO_REG != 0) && (gi == 0)) begin
                mem_reg[gi] <= '0;
            end else if (we1 && (wa1 == ADDR_W'(gi))) begin
                mem_reg[gi] <= wd1;
            end else if (we0 && (wa0 == ADDR_W'(gi))) begin
                mem_reg[gi] <= wd0;
            end else if (clr_active && (idx_reg == ADDR_W'(gi))) begin
                mem_reg[gi] <= '0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_rd_port (
            .mem (mem_reg),
            .addr(rd_addr[gi*ADDR_W +: ADDR_W]),
            .we0 (we0),
            .wa0 (wa0),
            .wd0 (wd0),
            .we1 (we1),
            .wa1 (wa1),
            .wd1 (wd1),
            .data(rd_data[gi*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        we0, we1, clr_req;
    logic [2:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic [11:0] ra;
    logic [15:0] rd_data0;
    logic [63:0] rd_data1;
    logic        busy0, busy1, col0, col1;

    regfile_mp dut0 (
        .clk(clk), .reset(reset),
        .rd_addr(ra[5:0]), .rd_data(rd_data0),
        .we0(we0), .wa0(wa0), .wd0(wd0[7:0]),
        .we1(we1), .wa1(wa1), .wd1(wd1[7:0]),
        .clr_req(clr_req), .clr_busy(busy0), .wr_collide(col0)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset),
        .rd_addr(ra), .rd_data(rd_data1),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_req(clr_req), .clr_busy(busy1), .wr_collide(col1)
    );

    typedef struct {
        int          kind;
        int          port;
        logic [15:0] exp;
        int          cyc;
    } chk_t;

    chk_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    logic [7:0]  m0 [8];
    logic [15:0] m1 [8];
    bit          swp_on   = 1'b0;
    int          swp_idx  = 0;
    bit          col_prev = 1'b0;

    function automatic string kname(input int k);
        case (k)
            0:       return "rd_dflt";
            1:       return "rd_zbyp";
            2:       return "clr_busy";
            default: return "wr_collide";
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end else begin
            $display("chk %s ok val=%h", name, got);
        end
    endtask

    task automatic step(input bit rst, input bit e0, input logic [2:0] a0, input logic [15:0] d0,
                        input bit e1, input logic [2:0] a1, input logic [15:0] d1,
                        input bit clr, input logic [11:0] r);
        logic [2:0]  a;
        logic [15:0] x;
        reset = rst; we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1; clr_req = clr; ra = r;
        for (int p = 0; p < 2; p++) begin
            a = r[p*3 +: 3];
            sb.push_back('{0, p, {8'h00, m0[a]}, cyc});
        end
        for (int p = 0; p < 4; p++) begin
            a = r[p*3 +: 3];
            if (a == 3'd0)              x = 16'h0000;
            else if (e1 && (a1 == a))   x = d1;
            else if (e0 && (a0 == a))   x = d0;
            else                        x = m1[a];
            sb.push_back('{1, p, x, cyc});
        end
        for (int d = 0; d < 2; d++) begin
            sb.push_back('{2, d, {15'd0, swp_on}, cyc});
            sb.push_back('{3, d, {15'd0, col_prev}, cyc});
        end
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m0[i] = '0;
                m1[i] = '0;
            end
            swp_on = 1'b0; swp_idx = 0; col_prev = 1'b0;
        end else begin
            col_prev = e0 && e1 && (a0 == a1);
            if (swp_on) begin
                m0[swp_idx] = '0;
                m1[swp_idx] = '0;
                swp_idx++;
                if (swp_idx == 8) begin
                    swp_on  = 1'b0;
                    swp_idx = 0;
                end
            end else if (clr) begin
                swp_on  = 1'b1;
                swp_idx = 0;
            end
            if (e0) begin m0[a0] = d0[7:0]; m1[a0] = d0; end
            if (e1) begin m0[a1] = d1[7:0]; m1[a1] = d1; end
            m1[0] = '0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [11:0] r);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, r);
    endtask

    function automatic logic [11:0] rpat(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    always @(negedge clk) begin
        chk_t        t;
        logic [15:0] act;
        int          n;
        int          e;
        int          c;
        n = 0; e = 0; c = 0;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            c = t.cyc;
            case (t.kind)
                0:       act = {8'h00, rd_data0[t.port*8 +: 8]};
                1:       act = rd_data1[t.port*16 +: 16];
                2:       act = {15'd0, (t.port == 0) ? busy0 : busy1};
                default: act = {15'd0, (t.port == 0) ? col0 : col1};
            endcase
            total++;
            n++;
            if (act !== t.exp) begin
                bad++;
                e++;
                $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", kname(t.kind), t.port, t.cyc, act, t.exp);
            end
        end
        if (n > 0) $display("txn cyc=%0d checks=%0d errors=%0d", c, n, e);
    end

    initial begin
        int w;
        for (int i = 0; i < 8; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        reset = 1'b1; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        clr_req = 0; ra = '0;
        @(posedge clk);
        #1;
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, rpat(0, 1, 2, 3));

        chk("reset_busy0", {15'd0, busy0}, 16'h0000);
        chk("reset_busy1", {15'd0, busy1}, 16'h0000);
        chk("reset_col0",  {15'd0, col0},  16'h0000);
        chk("reset_col1",  {15'd0, col1},  16'h0000);
        for (int p = 0; p < 2; p++) chk("reset_rd0", {8'h00, rd_data0[p*8 +: 8]}, 16'h0000);
        for (int p = 0; p < 4; p++) chk("reset_rd1", rd_data1[p*16 +: 16], 16'h0000);

        idle(rpat(4, 5, 6, 7));

        step(1'b0, 1, 3'd3, 16'h00A5, 0, 0, 0, 0, rpat(3, 3, 3, 3));
        idle(rpat(3, 3, 3, 3));
        for (int k = 0; k < 8; k += 2) idle(rpat(k, k + 1, k, k + 1));

        step(1'b0, 1, 3'd5, 16'h0011, 1, 3'd5, 16'h0022, 0, rpat(5, 5, 5, 5));
        idle(rpat(5, 5, 5, 5));
        idle(rpat(5, 4, 5, 4));

        step(1'b0, 0, 0, 0, 1, 3'd2, 16'h3C3C, 0, rpat(2, 2, 2, 2));
        idle(rpat(2, 3, 2, 5));

        for (int k = 0; k < 8; k++) step(1'b0, 1, 3'(k), 16'hFFFF, 0, 0, 0, 0, rpat(k, k, k, k));
        step(1'b0, 0, 0, 0, 0, 0, 0, 1, rpat(0, 1, 2, 3));
        for (int j = 1; j <= 10; j++) begin
            if (j == 5) step(1'b0, 1, 3'd4, 16'h0077, 0, 0, 0, 1, rpat(4, j % 8, 4, (j + 6) % 8));
            else        step(1'b0, 0, 0, 0, 0, 0, 0, (j == 3), rpat(j % 8, (j + 7) % 8, (j + 6) % 8, 4));
        end

        for (int k = 0; k < 8; k++) step(1'b0, 1, 3'(k), 16'hA000 + 16'(k), 0, 0, 0, 0, rpat(k, k, k, k));
        step(1'b0, 0, 0, 0, 0, 0, 0, 1, rpat(1, 2, 3, 4));
        idle(rpat(0, 1, 2, 3));
        idle(rpat(4, 5, 6, 7));
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, rpat(5, 6, 7, 1));
        idle(rpat(4, 5, 6, 7));
        step(1'b0, 1, 3'd6, 16'h5A5A, 0, 0, 0, 0, rpat(6, 6, 6, 6));
        step(1'b0, 0, 0, 0, 0, 0, 0, 1, rpat(6, 0, 6, 0));

        w = 0;
        while (((busy0 !== 1'b0) || (busy1 !== 1'b0)) && (w < 16)) begin
            idle(rpat(6, w % 8, 6, 7));
            w++;
        end
        total++;
        if (w >= 16) begin
            bad++;
            $display("FAIL sweep_wait expired after %0d cycles, busy0=%b busy1=%b", w, busy0, busy1);
        end else begin
            $display("chk sweep_wait ok cycles=%0d", w);
        end

        for (int j = 1; j <= 10; j++) idle(rpat(6, j % 8, 6, 7));

        step(1'b0, 1, 3'd0, 16'hBEEF, 1, 3'd7, 16'h1234, 0, rpat(0, 7, 0, 7));
        idle(rpat(0, 7, 0, 7));
        step(1'b0, 1, 3'd0, 16'h1111, 1, 3'd0, 16'h2222, 0, rpat(0, 0, 0, 0));
        idle(rpat(0, 7, 0, 7));

        for (int j = 0; j < 300; j++) begin
            logic [2:0]  a0, a1;
            logic [15:0] d0, d1;
            a0 = 3'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 3'($urandom_range(0, 7));
            d0 = 16'($urandom);
            d1 = 16'($urandom);
            step($urandom_range(0, 99) == 0, 1'($urandom), a0, d0, 1'($urandom), a1, d1,
                 $urandom_range(0, 24) == 0, 12'($urandom));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
